// File: rtl/seg_display_driver.sv
// Binary-to-BCD (sequential double-dabble) front end feeding a 4-digit,
// common-anode, time-multiplexed seven-segment display with leading-zero blanking.
module seg_display_driver #(
    parameter int CNT_W       = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_in,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             busy
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IT_W  = 4;
    localparam int BCD_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   sample_q, sample_d;
    logic [CNT_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [IT_W-1:0]    iter_q, iter_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+CNT_W-1:0] dd_shift;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    // Double-dabble correction: add 3 to any BCD nibble >= 5 before the shift.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                                 : bcd_q[gi*4 +: 4];
    end

    assign dd_shift = {bcd_adj, bin_q} << 1;

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        disp_d   = disp_q;
        case (state_q)
            IDLE: begin
                if (count_in != sample_q) begin
                    sample_d = count_in;
                    bin_d    = count_in;
                    bcd_d    = '0;
                    iter_d   = IT_W'(CNT_W);
                    state_d  = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d  = dd_shift[BCD_W+CNT_W-1:CNT_W];
                bin_d  = dd_shift[CNT_W-1:0];
                iter_d = iter_q - IT_W'(1);
                if (iter_q == IT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan timing is free-running; it never waits on the converter.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // seg is decoded from next-state display/index so it switches with an, and
    // shows a freshly converted value on the same edge the display register loads.
    always_comb begin
        an_d = ~(4'b0001 << idx_d);
        case (idx_d)
            2'd0:    seg_d = seg_code(disp_d[3:0]);
            2'd1:    seg_d = (disp_d[11:4] == 8'd0) ? 7'h7F : seg_code(disp_d[7:4]);
            2'd2:    seg_d = (disp_d[11:8] == 4'd0) ? 7'h7F : seg_code(disp_d[11:8]);
            default: seg_d = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sample_q <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            disp_q   <= '0;
            pre_q    <= '0;
            idx_q    <= 2'd0;
            an_q     <= 4'b1110;
            seg_q    <= 7'h40;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            disp_q   <= disp_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;
    assign busy = (state_q != IDLE);

endmodule
